// File: rtl/bcd_counter_mux_display.sv
// N-digit BCD up/down counter with load/clear and a time-multiplexed 7-segment driver.
// Count and scan rates come from clock-enable dividers; everything runs on CLK.
module bcd_counter_mux_display #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned TICK_DIV       = 100_000_000,
  parameter int unsigned SCAN_DIV       = 100_000,
  parameter int unsigned SEG_ACTIVE_LOW = 0,
  parameter int unsigned SEL_ACTIVE_LOW = 1,
  parameter int unsigned BLANK_LZ       = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  EN,
  input  logic                  UP_DN,
  input  logic                  CLR,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   LOAD_VAL,
  output logic [4*DIGITS-1:0]   COUNT,
  output logic                  WRAP,
  output logic [6:0]            SEG_C,
  output logic [DIGITS-1:0]     SEG_SEL
);

  localparam int unsigned CW  = 4 * DIGITS;
  localparam int unsigned PW  = $clog2(TICK_DIV);
  localparam int unsigned SDW = $clog2(SCAN_DIV);
  localparam int unsigned SW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [6:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
  localparam logic [DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PW-1:0]     presc_q, presc_d;
  logic [CW-1:0]     count_q, count_d;
  logic              wrap_q, wrap_d;
  logic [SDW-1:0]    scan_div_q, scan_div_d;
  logic [SW-1:0]     scan_idx_q, scan_idx_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] sel_q, sel_d;

  logic              tick;
  logic              carry;
  logic [3:0]        dig;
  logic [CW-1:0]     step;

  // Prescaler and count next-state; carry out of the top digit is the wrap condition.
  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    tick    = (presc_q == PW'(TICK_DIV - 1)) && EN;
    carry   = 1'b1;
    dig     = 4'd0;
    step    = count_q;

    for (int i = 0; i < int'(DIGITS); i++) begin
      dig = count_q[4*i +: 4];
      if (carry) begin
        if (UP_DN) begin
          if (dig == 4'd9) begin
            step[4*i +: 4] = 4'd0;
          end else begin
            step[4*i +: 4] = dig + 4'd1;
            carry          = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            step[4*i +: 4] = 4'd9;
          end else begin
            step[4*i +: 4] = dig - 4'd1;
            carry          = 1'b0;
          end
        end
      end
    end

    if (CLR) begin
      count_d = '0;
      presc_d = '0;
    end else if (LOAD) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        count_d[4*i +: 4] = (LOAD_VAL[4*i +: 4] > 4'd9) ? 4'd0 : LOAD_VAL[4*i +: 4];
      end
      presc_d = '0;
    end else begin
      if (EN) begin
        presc_d = tick ? '0 : presc_q + PW'(1);
      end
      if (tick) begin
        count_d = step;
        wrap_d  = carry;
      end
    end
  end

  logic [3:0] cur;
  logic       zero_above;
  logic       blank;
  logic [6:0] raw;
  logic [DIGITS-1:0] onehot;

  // Scan divider/index and display decode of the currently selected digit.
  always_comb begin
    scan_div_d = scan_div_q + SDW'(1);
    scan_idx_d = scan_idx_q;
    if (scan_div_q == SDW'(SCAN_DIV - 1)) begin
      scan_div_d = '0;
      scan_idx_d = (scan_idx_q == SW'(DIGITS - 1)) ? '0 : scan_idx_q + SW'(1);
    end

    cur        = 4'd0;
    zero_above = 1'b1;
    onehot     = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (SW'(i) == scan_idx_q) begin
        cur       = count_q[4*i +: 4];
        onehot[i] = 1'b1;
      end
      if ((i >= int'(scan_idx_q)) && (count_q[4*i +: 4] != 4'd0)) begin
        zero_above = 1'b0;
      end
    end
    blank = (BLANK_LZ != 0) && (scan_idx_q != '0) && zero_above;

    case (cur)
      4'd0:    raw = 7'h3f;
      4'd1:    raw = 7'h06;
      4'd2:    raw = 7'h5b;
      4'd3:    raw = 7'h4f;
      4'd4:    raw = 7'h66;
      4'd5:    raw = 7'h6d;
      4'd6:    raw = 7'h7d;
      4'd7:    raw = 7'h07;
      4'd8:    raw = 7'h7f;
      4'd9:    raw = 7'h6f;
      default: raw = 7'h00;
    endcase
    if (blank) begin
      raw = 7'h00;
    end

    seg_d = (SEG_ACTIVE_LOW != 0) ? ~raw : raw;
    sel_d = (SEL_ACTIVE_LOW != 0) ? ~onehot : onehot;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      presc_q    <= '0;
      count_q    <= '0;
      wrap_q     <= 1'b0;
      scan_div_q <= '0;
      scan_idx_q <= '0;
      seg_q      <= SEG_OFF;
      sel_q      <= SEL_OFF;
    end else begin
      presc_q    <= presc_d;
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      scan_div_q <= scan_div_d;
      scan_idx_q <= scan_idx_d;
      seg_q      <= seg_d;
      sel_q      <= sel_d;
    end
  end

  assign COUNT   = count_q;
  assign WRAP    = wrap_q;
  assign SEG_C   = seg_q;
  assign SEG_SEL = sel_q;

endmodule
